ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline. Holds the ID/EX pipeline register and the integer ALU, and resolves branch/jump redirects.
- Captures decode-stage controls at the clock edge, including the 3-bit ALU control code from the ALU decoder. Applies forwarding to the registered operands, then computes the ALU result, zero flag, branch target and PC-select.
- Downstream consumers: the EX/MEM register and the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 0, reset value of the registered PC fields.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- StallE  in  1  hold the ID/EX register contents
- FlushE  in  1  load a bubble into the ID/EX register
- ValidD  in  1  decode slot holds a real instruction
- RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD  in  1 each  decoded controls
- ResultSrcD  in  2  writeback select
- ALUControlD  in  3  ALU operation code
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  XLEN each  decode-stage operands
- Rs1D, Rs2D, RdD  in  5 each  register indices
- ForwardAE, ForwardBE  in  2 each  forwarding select (from hazard unit)
- ALUResultM, ResultW  in  XLEN each  forwarded values
- ValidE, RegWriteE, MemWriteE  out  1 each  registered controls (RegWriteE/MemWriteE gated by ValidE)
- ResultSrcE  out  2  registered writeback select
- Rs1E, Rs2E, RdE  out  5 each  registered indices (consumed by the hazard unit)
- ALUResultE, WriteDataE, PCTargetE, PCPlus4E  out  XLEN each
- ZeroE, PCSrcE  out  1 each

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All register fields clear to 0; PC field clears to RESET_PC.
  - ValidE=0, so RegWriteE=MemWriteE=PCSrcE=0.
  - Deassertion is sampled at the next rising edge.
- Register update at each rising edge, priority order:
  1. FlushE=1: bubble. Valid, RegWrite, MemWrite, Branch and Jump are cleared; data fields are don't-care but are cleared to 0.
  2. Else StallE=1: hold all fields.
  3. Else: load all D-stage inputs.
- FlushE and StallE together: flush wins.
- Datapath is combinational from the registered fields and forwarding inputs; zero added latency within EX.
- Operand A forwarding (ForwardAE): 00 = RD1E, 01 = ResultW, 10 = ALUResultM, 11 = RD1E.
- Operand B forwarding (ForwardBE): same mapping applied to RD2E; the selected value is WriteDataE.
- SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALUControl encoding:
  - 000 add; 001 sub (SrcA−SrcB); 010 and; 011 or.
  - 101 slt: signed compare; result is 1 if SrcA<SrcB, else 0, zero-extended.
  - Any other code: result 0.
- Arithmetic is modulo 2^XLEN; overflow is silently wrapped.
- ZeroE = (ALUResultE == 0).
- PCTargetE = PCE + ImmExtE, modulo 2^XLEN.
- PCSrcE = ValidE & ((BranchE & ZeroE) | JumpE).
- Outputs are gated by ValidE:
  - Bubbles never write registers or memory and never redirect.
  - ALUResultE is still computed from whatever the fields contain.
- Reset mid-operation: the in-flight instruction is discarded immediately; no output pulse survives the reset assertion.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle, with ValidE=1 and RegWriteE=1 held beforehand -> RegWriteE, ValidE and PCSrcE drop to 0 without a clock edge; PC field reads RESET_PC.
- ALU ops (ForwardAE=ForwardBE=00, ALUSrcD=0): RD1D=0x7FFFFFFF, RD2D=1.
  - add -> 0x80000000.
  - sub -> 0x7FFFFFFE.
  - slt with RD1D=0xFFFFFFFF, RD2D=1 -> 1.
  - and of 0xF0F0 and 0x0FF0 -> 0x00F0.
  - code 111 -> 0.
- Forwarding: RD1D=5, ALUResultM=9, ResultW=3, ALUControl=add, ImmExtD=2, ALUSrcD=1.
  - ForwardAE=10 -> ALUResultE=11.
  - ForwardAE=01 -> 5.
  - ForwardAE=11 -> 7.
- Branch: BranchD=1, sub, RD1D=RD2D=42, PCD=0x100, ImmExtD=0xFFFFFFF0 -> ZeroE=1, PCSrcE=1, PCTargetE=0xF0. With RD2D=43 -> PCSrcE=0.
- Stall/flush:
  - Load an add instruction, then assert StallE with new D inputs -> E fields unchanged for the stalled cycles.
  - Assert StallE and FlushE together -> ValidE=0, RegWriteE=0, PCSrcE=0 even with JumpD=1.
- Bubble: ValidD=0 with RegWriteD=1, MemWriteD=1, JumpD=1 -> RegWriteE=MemWriteE=PCSrcE=0 after the edge.

Source files
------------

// File: rtl/ex_stage_if.sv
// Execute-stage bus: decode-side operands/controls and hazard-unit forwarding in,
// registered E-stage controls and datapath results out.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            StallE, FlushE;
  logic            ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD;
  logic [1:0]      ResultSrcD;
  logic [2:0]      ALUControlD;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] ALUResultM, ResultW;

  logic            ValidE, RegWriteE, MemWriteE;
  logic [1:0]      ResultSrcE;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic [XLEN-1:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
  logic            ZeroE, PCSrcE;

  modport master (
    output StallE, FlushE, ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD,
           ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    input  ValidE, RegWriteE, MemWriteE, ResultSrcE, Rs1E, Rs2E, RdE,
           ALUResultE, WriteDataE, PCTargetE, PCPlus4E, ZeroE, PCSrcE
  );

  modport slave (
    input  StallE, FlushE, ValidD, RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcD,
           ResultSrcD, ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
           Rs1D, Rs2D, RdD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    output ValidE, RegWriteE, MemWriteE, ResultSrcE, Rs1E, Rs2E, RdE,
           ALUResultE, WriteDataE, PCTargetE, PCPlus4E, ZeroE, PCSrcE
  );
endinterface

// File: rtl/ex_stage.sv
// RISC-V execute stage: ID/EX pipeline register, operand forwarding, integer ALU
// and branch/jump redirect resolution.
module ex_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  ex_stage_if.slave   ex
);

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memwrite;
    logic            branch;
    logic            jump;
    logic            alusrc;
    logic [1:0]      resultsrc;
    logic [2:0]      alucontrol;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } idex_t;

  idex_t           idex_reg;
  idex_t           idex_next;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  always_comb begin
    idex_next            = '0;
    idex_next.valid      = ex.ValidD;
    idex_next.regwrite   = ex.RegWriteD;
    idex_next.memwrite   = ex.MemWriteD;
    idex_next.branch     = ex.BranchD;
    idex_next.jump       = ex.JumpD;
    idex_next.alusrc     = ex.ALUSrcD;
    idex_next.resultsrc  = ex.ResultSrcD;
    idex_next.alucontrol = ex.ALUControlD;
    idex_next.rd1        = ex.RD1D;
    idex_next.rd2        = ex.RD2D;
    idex_next.imm        = ex.ImmExtD;
    idex_next.pc         = ex.PCD;
    idex_next.pcplus4    = ex.PCPlus4D;
    idex_next.rs1        = ex.Rs1D;
    idex_next.rs2        = ex.Rs2D;
    idex_next.rd         = ex.RdD;
  end

  // Flush outranks stall so a squashed slot can never be held as live.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_reg    <= '0;
      idex_reg.pc <= RESET_PC;
    end else if (ex.FlushE) begin
      idex_reg <= '0;
    end else if (!ex.StallE) begin
      idex_reg <= idex_next;
    end
  end

  always_comb begin
    case (ex.ForwardAE)
      2'b01:   src_a = ex.ResultW;
      2'b10:   src_a = ex.ALUResultM;
      default: src_a = idex_reg.rd1;
    endcase
    case (ex.ForwardBE)
      2'b01:   write_data = ex.ResultW;
      2'b10:   write_data = ex.ALUResultM;
      default: write_data = idex_reg.rd2;
    endcase
  end

  assign src_b = idex_reg.alusrc ? idex_reg.imm : write_data;

  always_comb begin
    case (idex_reg.alucontrol)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Side effects are masked by valid so bubbles never write or redirect.
  assign ex.ValidE     = idex_reg.valid;
  assign ex.RegWriteE  = idex_reg.valid & idex_reg.regwrite;
  assign ex.MemWriteE  = idex_reg.valid & idex_reg.memwrite;
  assign ex.PCSrcE     = idex_reg.valid & ((idex_reg.branch & zero) | idex_reg.jump);
  assign ex.ResultSrcE = idex_reg.resultsrc;
  assign ex.Rs1E       = idex_reg.rs1;
  assign ex.Rs2E       = idex_reg.rs2;
  assign ex.RdE        = idex_reg.rd;
  assign ex.ALUResultE = alu_result;
  assign ex.WriteDataE = write_data;
  assign ex.PCTargetE  = idex_reg.pc + idex_reg.imm;
  assign ex.PCPlus4E   = idex_reg.pcplus4;
  assign ex.ZeroE      = zero;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: behavioural model of the instruction held in EX,
// directed literal cases and randomized traffic.
module tb_ex_stage;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  bit   cmp_en;

  ex_stage_if #(.XLEN(32)) exif ();

  ex_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ex      (exif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The instruction the model believes is sitting in EX.
  typedef struct packed {
    logic        v, rw, mw, br, jp, src;
    logic [1:0]  rs;
    logic [2:0]  op;
    logic [31:0] a, b, imm, pc, pc4;
    logic [4:0]  r1, r2, rd;
  } ex_t;

  ex_t m;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          m <= '0;
    else if (exif.FlushE)  m <= '0;
    else if (!exif.StallE) m <= '{exif.ValidD, exif.RegWriteD, exif.MemWriteD, exif.BranchD,
                                  exif.JumpD, exif.ALUSrcD, exif.ResultSrcD, exif.ALUControlD,
                                  exif.RD1D, exif.RD2D, exif.ImmExtD, exif.PCD, exif.PCPlus4D,
                                  exif.Rs1D, exif.Rs2D, exif.RdD};
  end

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] reg_val);
    if (sel == 2'b01) return exif.ResultW;
    if (sel == 2'b10) return exif.ALUResultM;
    return reg_val;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] fa, fb, res;
      logic        z;
      fa  = pick(exif.ForwardAE, m.a);
      fb  = pick(exif.ForwardBE, m.b);
      res = ref_alu(m.op, fa, m.src ? m.imm : fb);
      z   = (res == 32'd0);
      chk("m_alu",      exif.ALUResultE, res);
      chk("m_zero",     {31'd0, exif.ZeroE}, {31'd0, z});
      chk("m_wdata",    exif.WriteDataE, fb);
      chk("m_target",   exif.PCTargetE, m.pc + m.imm);
      chk("m_pc4",      exif.PCPlus4E, m.pc4);
      chk("m_valid",    {31'd0, exif.ValidE}, {31'd0, m.v});
      chk("m_regwrite", {31'd0, exif.RegWriteE}, {31'd0, m.v && m.rw});
      chk("m_memwrite", {31'd0, exif.MemWriteE}, {31'd0, m.v && m.mw});
      chk("m_pcsrc",    {31'd0, exif.PCSrcE}, {31'd0, m.v && ((m.br && z) || m.jp)});
      chk("m_rsrc",     {30'd0, exif.ResultSrcE}, {30'd0, m.rs});
      chk("m_regs",     {17'd0, exif.Rs1E, exif.Rs2E, exif.RdE}, {17'd0, m.r1, m.r2, m.rd});
    end
  end

  task automatic set_d(input logic v, input logic rw, input logic mw, input logic br,
                       input logic jp, input logic src, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc);
    exif.ValidD = v;  exif.RegWriteD = rw; exif.MemWriteD = mw;
    exif.BranchD = br; exif.JumpD = jp;    exif.ALUSrcD = src;
    exif.ALUControlD = op; exif.ResultSrcD = 2'b01;
    exif.RD1D = a; exif.RD2D = b; exif.ImmExtD = imm;
    exif.PCD = pc; exif.PCPlus4D = pc + 32'd4;
    exif.Rs1D = 5'd1; exif.Rs2D = 5'd2; exif.RdD = 5'd3;
    exif.StallE = 1'b0; exif.FlushE = 1'b0;
    exif.ForwardAE = 2'b00; exif.ForwardBE = 2'b00;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic alu_case(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    set_d(1, 1, 0, 0, 0, 0, op, a, b, 32'd0, 32'd0);
    tick;
    $display("txn %s op=%0d a=0x%08h b=0x%08h res=0x%08h", name, op, a, b, exif.ALUResultE);
    chk(name, exif.ALUResultE, exp);
  endtask

  initial begin
    checks = 0; failures = 0; cmp_en = 1'b0;
    reset_n = 1'b0;
    exif.ALUResultM = 32'd0; exif.ResultW = 32'd0;
    set_d(0, 0, 0, 0, 0, 0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    cmp_en = 1'b1;

    // Asynchronous reset with a live jumping, writing instruction in EX
    set_d(1, 1, 0, 0, 1, 0, 3'd0, 32'd1, 32'd2, 32'h10, 32'h200);
    tick;
    $display("txn pre_reset valid=%0b regwrite=%0b pcsrc=%0b", exif.ValidE, exif.RegWriteE, exif.PCSrcE);
    chk("pre_rst_valid", {31'd0, exif.ValidE}, 32'd1);
    chk("pre_rst_regwrite", {31'd0, exif.RegWriteE}, 32'd1);
    chk("pre_rst_pcsrc", {31'd0, exif.PCSrcE}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    $display("txn async_reset valid=%0b regwrite=%0b pcsrc=%0b target=0x%08h",
             exif.ValidE, exif.RegWriteE, exif.PCSrcE, exif.PCTargetE);
    chk("rst_valid", {31'd0, exif.ValidE}, 32'd0);
    chk("rst_regwrite", {31'd0, exif.RegWriteE}, 32'd0);
    chk("rst_pcsrc", {31'd0, exif.PCSrcE}, 32'd0);
    chk("rst_pc", exif.PCTargetE, 32'd0);
    reset_n = 1'b1;

    alu_case("alu_add", 3'b000, 32'h7FFFFFFF, 32'd1, 32'h80000000);
    alu_case("alu_sub", 3'b001, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFE);
    alu_case("alu_slt", 3'b101, 32'hFFFFFFFF, 32'd1, 32'd1);
    alu_case("alu_and", 3'b010, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0);
    alu_case("alu_111", 3'b111, 32'h7FFFFFFF, 32'd1, 32'd0);

    // Forwarding onto operand A with an immediate operand B
    set_d(1, 1, 0, 0, 0, 1, 3'b000, 32'd5, 32'd0, 32'd2, 32'd0);
    exif.ALUResultM = 32'd9; exif.ResultW = 32'd3; exif.ForwardAE = 2'b10;
    tick;
    chk("fwd_mem", exif.ALUResultE, 32'd11);
    exif.ForwardAE = 2'b01;
    #1 chk("fwd_wb", exif.ALUResultE, 32'd5);
    exif.ForwardAE = 2'b11;
    #1 chk("fwd_11", exif.ALUResultE, 32'd7);
    $display("txn forward res=0x%08h", exif.ALUResultE);

    set_d(1, 0, 0, 1, 0, 0, 3'b001, 32'd42, 32'd42, 32'hFFFFFFF0, 32'h100);
    tick;
    $display("txn branch_taken zero=%0b pcsrc=%0b target=0x%08h", exif.ZeroE, exif.PCSrcE, exif.PCTargetE);
    chk("br_zero", {31'd0, exif.ZeroE}, 32'd1);
    chk("br_pcsrc", {31'd0, exif.PCSrcE}, 32'd1);
    chk("br_target", exif.PCTargetE, 32'hF0);
    set_d(1, 0, 0, 1, 0, 0, 3'b001, 32'd42, 32'd43, 32'hFFFFFFF0, 32'h100);
    tick;
    $display("txn branch_not_taken pcsrc=%0b", exif.PCSrcE);
    chk("br_nt_pcsrc", {31'd0, exif.PCSrcE}, 32'd0);

    // Stall holds the add while new decode inputs wait
    set_d(1, 1, 0, 0, 0, 0, 3'b000, 32'd10, 32'd20, 32'd0, 32'h40);
    exif.RdD = 5'd7;
    tick;
    chk("stall_load", exif.ALUResultE, 32'd30);
    set_d(1, 1, 1, 0, 1, 0, 3'b001, 32'd99, 32'd1, 32'd4, 32'h80);
    exif.RdD = 5'd9; exif.StallE = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick;
      $display("txn stall cyc=%0d res=0x%08h rd=%0d", c, exif.ALUResultE, exif.RdE);
      chk("stall_alu", exif.ALUResultE, 32'd30);
      chk("stall_rd", {27'd0, exif.RdE}, 32'd7);
      chk("stall_pcsrc", {31'd0, exif.PCSrcE}, 32'd0);
    end
    exif.FlushE = 1'b1;
    tick;
    $display("txn stall_flush valid=%0b regwrite=%0b pcsrc=%0b", exif.ValidE, exif.RegWriteE, exif.PCSrcE);
    chk("sf_valid", {31'd0, exif.ValidE}, 32'd0);
    chk("sf_regwrite", {31'd0, exif.RegWriteE}, 32'd0);
    chk("sf_pcsrc", {31'd0, exif.PCSrcE}, 32'd0);

    set_d(0, 1, 1, 0, 1, 0, 3'b000, 32'd1, 32'd1, 32'd0, 32'd0);
    tick;
    $display("txn bubble regwrite=%0b memwrite=%0b pcsrc=%0b", exif.RegWriteE, exif.MemWriteE, exif.PCSrcE);
    chk("bub_regwrite", {31'd0, exif.RegWriteE}, 32'd0);
    chk("bub_memwrite", {31'd0, exif.MemWriteE}, 32'd0);
    chk("bub_pcsrc", {31'd0, exif.PCSrcE}, 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      set_d($urandom_range(0, 9) < 8, 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 4) == 0, 1'($urandom), 3'($urandom),
            a, ($urandom_range(0, 2) == 0) ? a : $urandom, $urandom, $urandom);
      exif.ResultSrcD = 2'($urandom);
      exif.Rs1D = 5'($urandom); exif.Rs2D = 5'($urandom); exif.RdD = 5'($urandom);
      exif.ForwardAE = 2'($urandom); exif.ForwardBE = 2'($urandom);
      exif.ALUResultM = ($urandom_range(0, 3) == 0) ? a : $urandom;
      exif.ResultW = $urandom;
      exif.StallE = $urandom_range(0, 4) == 0;
      exif.FlushE = $urandom_range(0, 9) == 0;
      tick;
      $display("txn rnd %0d st=%0b fl=%0b op=%0d fa=%0d fb=%0d res=0x%08h pcsrc=%0b",
               i, exif.StallE, exif.FlushE, m.op, exif.ForwardAE, exif.ForwardBE,
               exif.ALUResultE, exif.PCSrcE);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
